// File: rtl/cpu_pkg.sv
// Shared CPU types: data word, loader FSM states and frame sync marker.
package cpu_pkg;

    typedef logic [7:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        INSTR,
        IMM,
        WRITE,
        CHK
    } e_ldr_state;

    localparam word_t LDR_SYNC = 8'hA5;

    function automatic logic ldr_timed(input e_ldr_state s);
        return (s == LEN) || (s == INSTR) || (s == IMM) || (s == CHK);
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Idle-cycle counter; pulses expired on the TIMEOUT-th consecutive enabled cycle.
module byte_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         hit;

    assign hit     = (cnt_q == W'(TIMEOUT - 1));
    assign expired = en && hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader driving the instruction memory write port;
// keeps the CPU in reset until a checksum-verified frame has been written.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 1000,
    parameter logic [7:0]  SYNC_BYTE = LDR_SYNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_instr,
    output logic [7:0]        imem_imm,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_ok,
    output logic              load_err
);

    e_ldr_state        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    word_t             instr_q, instr_d;
    word_t             imm_q, imm_d;
    word_t             chk_q, chk_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              run_q, run_d;

    logic xfer;
    logic timed;
    logic expired;

    assign xfer  = in_valid && in_ready;
    assign timed = ldr_timed(state_q);

    byte_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (xfer || !timed),
        .en     (timed && !xfer),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        chk_d   = chk_q;
        ok_d    = ok_q;
        err_d   = err_q;
        run_d   = run_q;

        unique case (state_q)
            IDLE: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    state_d = LEN;
                    run_d   = 1'b0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    chk_d   = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    cnt_d   = ADDR_W'(in_data);
                    chk_d   = chk_q ^ in_data;
                    state_d = INSTR;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            INSTR: begin
                if (xfer) begin
                    instr_d = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = IMM;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            IMM: begin
                if (xfer) begin
                    imm_d   = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = WRITE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // A count of 0 means a full 2^ADDR_W words, so test before decrementing.
                cnt_d   = cnt_q - 1'b1;
                addr_d  = addr_q + 1'b1;
                state_d = (cnt_q == ADDR_W'(1)) ? CHK : INSTR;
            end
            CHK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        ok_d  = 1'b1;
                        run_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            chk_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            chk_q   <= chk_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    assign in_ready   = (state_q != WRITE);
    assign imem_wr_en = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_instr = instr_q;
    assign imem_imm   = imm_q;
    assign cpu_rst_n  = run_q;
    assign load_busy  = (state_q != IDLE);
    assign load_ok    = ok_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames, monitor checks each write.
module tb_prog_loader;

    localparam int TO = 40;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       imem_wr_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_instr;
    logic [7:0] imem_imm;
    logic       cpu_rst_n;
    logic       load_busy;
    logic       load_ok;
    logic       load_err;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  pl[$];

    prog_loader #(
        .ADDR_W   (8),
        .TIMEOUT  (TO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_wr_en(imem_wr_en),
        .imem_addr (imem_addr),
        .imem_instr(imem_instr),
        .imem_imm  (imem_imm),
        .cpu_rst_n (cpu_rst_n),
        .load_busy (load_busy),
        .load_ok   (load_ok),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {8'd0, imem_addr, imem_instr, imem_imm}, 32'hFFFFFFFF);
            end else begin
                check("write_word", {8'd0, imem_addr, imem_instr, imem_imm},
                      {8'd0, exp_q.pop_front()});
            end
        end else begin
            check("ready_high", {31'd0, in_ready}, 32'd1);
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) check("send_ready_timeout", 32'd0, 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic ok, input logic err,
                               input logic run, input logic busy);
        check(name, {28'd0, load_ok, load_err, cpu_rst_n, load_busy},
              {28'd0, ok, err, run, busy});
    endtask

    task automatic run_frame(input logic [7:0] len_b, input logic [7:0] chk_b,
                             input logic good);
        send(8'hA5);
        send(len_b);
        for (int i = 0; i < pl.size() / 2; i++) begin
            exp_q.push_back({8'(i), pl[2*i], pl[2*i+1]});
            send(pl[2*i]);
            send(pl[2*i+1]);
        end
        send(chk_b);
        @(negedge clk);
        check_flags("frame_flags", good, !good, good, 1'b0);
        check("frame_all_written", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {in_ready, imem_wr_en, imem_addr, imem_instr, imem_imm,
               cpu_rst_n, load_busy, load_ok, load_err},
              {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        // Garbage outside a frame is swallowed.
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        @(negedge clk);
        check_flags("garbage_flags", 1'b0, 1'b0, 1'b0, 1'b0);

        pl = {8'h21, 8'h05};
        run_frame(8'h01, 8'h25, 1'b1);

        pl = {8'h11, 8'h03, 8'hC4, 8'h07};
        run_frame(8'h02, 8'hD3, 1'b1);
        check("addr_after_two", {24'd0, imem_addr}, 32'd2);

        pl = {8'h21, 8'h05};
        run_frame(8'h01, 8'h24, 1'b0);

        // Timeout in IMM: TO-1 idle cycles keep the frame alive, the TO-th aborts.
        send(8'hA5);
        check_flags("sync_clears_err", 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h01);
        send(8'h21);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check_flags("before_timeout", 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_flags("after_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
        check("timeout_no_write", exp_q.size(), 32'd0);

        // Byte landing exactly on the limit cycle wins.
        send(8'hA5);
        send(8'h01);
        send(8'h21);
        repeat (TO - 1) @(posedge clk);
        exp_q.push_back({8'h00, 8'h21, 8'h05});
        send(8'h05);
        send(8'h25);
        @(negedge clk);
        check_flags("limit_byte_wins", 1'b1, 1'b0, 1'b1, 1'b0);
        check("limit_written", exp_q.size(), 32'd0);

        // Asynchronous reset mid-frame.
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        @(negedge clk);
        check("midframe_instr", {24'd0, imem_instr}, 32'h11);
        rst = 1'b1;
        #1;
        check("midframe_reset",
              {in_ready, imem_wr_en, imem_addr, imem_instr, imem_imm,
               cpu_rst_n, load_busy, load_ok, load_err},
              {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // LEN=0: 256 words, instr=i, imm=~i, so every byte XOR cancels to 00.
        pl = {};
        for (int i = 0; i < 256; i++) begin
            pl.push_back(8'(i));
            pl.push_back(~8'(i));
        end
        run_frame(8'h00, 8'h00, 1'b1);
        check("addr_wrapped", {24'd0, imem_addr}, 32'd0);
        check("last_word", {16'd0, imem_instr, imem_imm}, 32'hFF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
